// File: rtl/axi_4_master_burst_ctrl_if.sv
// AXI4 handshake bundle between the burst controller (master) and the
// interconnect/slave side. Only valid/ready/last/resp signals travel here;
// addresses and data are carried by the datapath next to the controller.
interface axi_4_master_burst_ctrl_if;
    logic       s_arready;
    logic       m_arvalid;
    logic       s_rvalid;
    logic       s_rlast;
    logic [1:0] s_rresp;
    logic       m_rready;
    logic       s_awready;
    logic       m_awvalid;
    logic       s_wready;
    logic       m_wvalid;
    logic       m_wlast;
    logic       s_bvalid;
    logic [1:0] s_bresp;
    logic       m_bready;

    modport master (
        input  s_arready, s_rvalid, s_rlast, s_rresp, s_awready, s_wready, s_bvalid, s_bresp,
        output m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready
    );

    modport slave (
        output s_arready, s_rvalid, s_rlast, s_rresp, s_awready, s_wready, s_bvalid, s_bresp,
        input  m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready
    );
endinterface

// File: rtl/axi_4_master_burst_ctrl.sv
// AXI4 master burst handshake controller for the VLSU.
// One load or store burst per request; counts beats, generates WLAST,
// keeps AW and W independent, reports the worst response and RLAST errors.
// Optional watchdog: define AXI4_MASTER_TIMEOUT_EN to enable it.
module axi_4_master_burst_ctrl #(
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ld_req,
    input  logic                         st_req,
    input  logic [LEN_W-1:0]             burst_len,
    output logic                         req_ready,
    axi_4_master_burst_ctrl_if.master    axi,
    output logic                         rd_beat_en,
    output logic                         wr_beat_en,
    output logic [LEN_W-1:0]             beat_idx,
    output logic                         done,
    output logic [1:0]                   resp,
    output logic                         err_rlast,
    output logic                         err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR,
        S_WR_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [1:0]       resp_q, resp_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic             err_rlast_q, err_rlast_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;

    logic             wvalid;
    logic             ar_hs, aw_hs, b_hs;
    logic             beat_last, beat_max;
    logic             timeout_fire;

    // Valids/readies decode from registered state only, never from a ready input.
    assign req_ready      = (state_q == S_IDLE);
    assign axi.m_arvalid  = (state_q == S_RD_ADDR);
    assign axi.m_rready   = (state_q == S_RD_DATA);
    assign axi.m_awvalid  = (state_q == S_WR) && !aw_done_q;
    assign wvalid         = (state_q == S_WR) && !w_done_q;
    assign axi.m_wvalid   = wvalid;
    assign axi.m_wlast    = wvalid && beat_last;
    assign axi.m_bready   = (state_q == S_WR_RESP);

    assign ar_hs      = (state_q == S_RD_ADDR) && axi.s_arready;
    assign aw_hs      = axi.m_awvalid && axi.s_awready;
    assign b_hs       = (state_q == S_WR_RESP) && axi.s_bvalid;
    assign rd_beat_en = (state_q == S_RD_DATA) && axi.s_rvalid;
    assign wr_beat_en = wvalid && axi.s_wready;

    assign beat_last  = (beat_q == len_q);
    assign beat_max   = &beat_q;

    assign beat_idx    = beat_q;
    assign done        = done_q;
    assign resp        = resp_q;
    assign err_rlast   = err_rlast_q;
    assign err_timeout = tmo_q;

`ifdef AXI4_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            any_hs;

    assign any_hs       = ar_hs || rd_beat_en || aw_hs || wr_beat_en || b_hs;
    assign timeout_fire = (state_q != S_IDLE) && !any_hs && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts consecutive busy cycles without any handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_q <= '0;
        else if (state_q == S_IDLE || any_hs || timeout_fire)
            wd_q <= '0;
        else
            wd_q <= wd_q + 1'b1;
    end
`else
    // Watchdog compiled out; the parameter stays so both builds share one port list.
    assign timeout_fire = (TIMEOUT_CYCLES < 0);
`endif

    // State and burst bookkeeping registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            beat_q      <= '0;
            resp_q      <= 2'b00;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_rlast_q <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            resp_q      <= resp_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            err_rlast_q <= err_rlast_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next-state logic: request accept, beat counting, response folding.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        beat_d      = beat_q;
        resp_d      = resp_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        err_rlast_d = err_rlast_q;
        done_d      = 1'b0;
        tmo_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ld_req || st_req) begin
                    len_d       = burst_len;
                    beat_d      = '0;
                    resp_d      = 2'b00;
                    err_rlast_d = 1'b0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = ld_req ? S_RD_ADDR : S_WR;
                end
            end
            S_RD_ADDR: begin
                if (ar_hs)
                    state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (rd_beat_en) begin
                    if (axi.s_rresp > resp_q)
                        resp_d = axi.s_rresp;
                    if (axi.s_rlast) begin
                        if (!beat_last)
                            err_rlast_d = 1'b1;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Expected last beat without RLAST: flag it and keep draining.
                        if (beat_last)
                            err_rlast_d = 1'b1;
                        if (!beat_max)
                            beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_WR: begin
                if (aw_hs)
                    aw_done_d = 1'b1;
                if (wr_beat_en) begin
                    if (beat_last)
                        w_done_d = 1'b1;
                    else
                        beat_d = beat_q + 1'b1;
                end
                if (aw_done_d && w_done_d)
                    state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    if (axi.s_bresp > resp_q)
                        resp_d = axi.s_bresp;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout_fire) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            tmo_d   = 1'b1;
            resp_d  = 2'b10;
        end
    end

endmodule

// File: tb/tb_axi_4_master_burst_ctrl.sv
// Self-checking bench for axi_4_master_burst_ctrl. Directed scenarios plus
// randomized load/store bursts, each checked against a transaction-level model
// (beat counts, max response, RLAST position). Define AXI4_MASTER_TIMEOUT_EN
// to exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_axi_4_master_burst_ctrl;

    localparam int LEN_W = 8;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             ld_req = 1'b0;
    logic             st_req = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             req_ready, rd_beat_en, wr_beat_en, done, err_rlast, err_timeout;
    logic [LEN_W-1:0] beat_idx;
    logic [1:0]       resp;

    int checks = 0;
    int errors = 0;

    axi_4_master_burst_ctrl_if axi ();

    axi_4_master_burst_ctrl #(
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_req      (ld_req),
        .st_req      (st_req),
        .burst_len   (burst_len),
        .req_ready   (req_ready),
        .axi         (axi.master),
        .rd_beat_en  (rd_beat_en),
        .wr_beat_en  (wr_beat_en),
        .beat_idx    (beat_idx),
        .done        (done),
        .resp        (resp),
        .err_rlast   (err_rlast),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached: got running, expected finished");
        $fatal(1, "time limit");
    end

    function automatic logic [21:0] all_outs();
        return {req_ready, axi.m_arvalid, axi.m_rready, axi.m_awvalid, axi.m_wvalid,
                axi.m_wlast, axi.m_bready, rd_beat_en, wr_beat_en, beat_idx, done,
                resp, err_rlast, err_timeout};
    endfunction

    task automatic drive_idle();
        ld_req         = 1'b0;
        st_req         = 1'b0;
        axi.s_arready  = 1'b0;
        axi.s_rvalid   = 1'b0;
        axi.s_rlast    = 1'b0;
        axi.s_rresp    = 2'b00;
        axi.s_awready  = 1'b0;
        axi.s_wready   = 1'b0;
        axi.s_bvalid   = 1'b0;
        axi.s_bresp    = 2'b00;
    endtask

    // Load burst: model expects beats 0..rlast_at, resp = max(rresp), err if rlast_at != len.
    task automatic run_load(input int len, input int rlast_at, input int ar_delay, input bit gaps,
                            input bit rresp_rand, input int bad_beat, input bit both_req,
                            input bit back2back);
        int         i, cyc;
        logic [1:0] exp_resp, rr;
        bit         exp_err;
        logic [6:0] got, exp;
        exp_resp = 2'b00;
        exp_err  = (rlast_at != len);
        if (!back2back) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if ({req_ready, done} !== {1'b1, back2back}) begin
            errors++;
            $display("FAIL load_accept {req_ready,done}=%b expected %b", {req_ready, done}, {1'b1, back2back});
        end
        ld_req    = 1'b1;
        st_req    = both_req;
        burst_len = len[LEN_W-1:0];
        @(negedge clk);
        ld_req = 1'b0;
        st_req = 1'b0;
        for (int d = 0; d <= ar_delay; d++) begin
            if (d > 0) @(negedge clk);
            axi.s_arready = (d == ar_delay);
            #1;
            checks++;
            if ({req_ready, axi.m_arvalid, axi.m_awvalid, axi.m_rready, done} !== 5'b01000) begin
                errors++;
                $display("FAIL load_ar_phase cycle %0d {rdy,arv,awv,rrdy,done}=%b expected 01000", d,
                         {req_ready, axi.m_arvalid, axi.m_awvalid, axi.m_rready, done});
            end
        end
        i   = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            axi.s_arready = 1'b0;
            axi.s_rvalid  = !gaps || (cyc % 8 == 7) || ($urandom_range(0, 2) != 0);
            rr            = (i == bad_beat) ? 2'b10 : (rresp_rand ? 2'($urandom_range(0, 3)) : 2'b00);
            axi.s_rresp   = axi.s_rvalid ? rr : 2'b00;
            axi.s_rlast   = axi.s_rvalid && (i == rlast_at);
            #1;
            checks++;
            if ({axi.m_arvalid, axi.m_rready, rd_beat_en, done} !== {1'b0, 1'b1, axi.s_rvalid, 1'b0}) begin
                errors++;
                $display("FAIL load_r_phase beat %0d {arv,rrdy,rd_en,done}=%b expected %b", i,
                         {axi.m_arvalid, axi.m_rready, rd_beat_en, done}, {1'b0, 1'b1, axi.s_rvalid, 1'b0});
            end
            if (axi.s_rvalid) begin
                checks++;
                if (beat_idx !== LEN_W'(i)) begin
                    errors++;
                    $display("FAIL load_beat_idx got %0d expected %0d", beat_idx, i);
                end
                if (rr > exp_resp) exp_resp = rr;
                if (i == rlast_at) break;
                i++;
            end
            cyc++;
            if (cyc > 2000) begin
                errors++;
                $display("FAIL load_r_bound no RLAST exit after %0d cycles, expected exit", cyc);
                break;
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        got = {done, req_ready, resp, err_rlast, err_timeout, axi.m_rready};
        exp = {1'b1, 1'b1, exp_resp, exp_err, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL load_done {done,rdy,resp,err_rlast,err_tmo,rrdy}=%b expected %b", got, exp);
        end
    endtask

    // Store burst: model expects len+1 W beats, WLAST on the last only, AW held until aw_delay.
    task automatic run_store(input int len, input int aw_delay, input int w_pct, input int b_delay,
                             input logic [1:0] bresp, input bit back2back);
        int         w_cnt, cyc, aw_hi;
        bit         aw_seen, ev_aw, ev_w, ev_wl;
        logic [5:0] got, exp;
        w_cnt   = 0;
        cyc     = 0;
        aw_hi   = 0;
        aw_seen = 1'b0;
        if (!back2back) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if ({req_ready, done} !== {1'b1, back2back}) begin
            errors++;
            $display("FAIL store_accept {req_ready,done}=%b expected %b", {req_ready, done}, {1'b1, back2back});
        end
        st_req    = 1'b1;
        burst_len = len[LEN_W-1:0];
        @(negedge clk);
        st_req = 1'b0;
        while (!(aw_seen && w_cnt > len)) begin
            if (cyc > 0) @(negedge clk);
            axi.s_awready = !aw_seen && (cyc >= aw_delay);
            axi.s_wready  = (cyc % 8 == 7) || ($urandom_range(1, 100) <= w_pct);
            #1;
            ev_aw = !aw_seen;
            ev_w  = (w_cnt <= len);
            ev_wl = ev_w && (w_cnt == len);
            got   = {axi.m_awvalid, axi.m_wvalid, axi.m_wlast, wr_beat_en, axi.m_bready, done};
            exp   = {ev_aw, ev_w, ev_wl, ev_w && axi.s_wready, 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL store_wr_phase cycle %0d {awv,wv,wlast,wr_en,brdy,done}=%b expected %b", cyc, got, exp);
            end
            if (ev_w) begin
                checks++;
                if (beat_idx !== LEN_W'(w_cnt)) begin
                    errors++;
                    $display("FAIL store_beat_idx got %0d expected %0d", beat_idx, w_cnt);
                end
            end
            if (axi.m_awvalid === 1'b1) aw_hi++;
            if (ev_aw && axi.s_awready) aw_seen = 1'b1;
            if (ev_w && axi.s_wready) w_cnt++;
            cyc++;
            if (cyc > 3000) begin
                errors++;
                $display("FAIL store_wr_bound still in WR after %0d cycles, expected exit", cyc);
                break;
            end
        end
        checks++;
        if (aw_hi != aw_delay + 1) begin
            errors++;
            $display("FAIL store_awvalid_hold high %0d cycles, expected %0d", aw_hi, aw_delay + 1);
        end
        for (int d = 0; d <= b_delay; d++) begin
            @(negedge clk);
            axi.s_awready = 1'b0;
            axi.s_wready  = 1'b0;
            axi.s_bvalid  = (d == b_delay);
            axi.s_bresp   = (d == b_delay) ? bresp : 2'b00;
            #1;
            checks++;
            if ({axi.m_awvalid, axi.m_wvalid, axi.m_bready, done} !== 4'b0010) begin
                errors++;
                $display("FAIL store_b_phase {awv,wv,brdy,done}=%b expected 0010",
                         {axi.m_awvalid, axi.m_wvalid, axi.m_bready, done});
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        got = {done, req_ready, resp, err_rlast, err_timeout};
        exp = {1'b1, 1'b1, bresp, 1'b0, 1'b0};
        checks++;
        if (got[5:0] !== exp[5:0]) begin
            errors++;
            $display("FAIL store_done {done,rdy,resp,err_rlast,err_tmo}=%b expected %b", got, exp);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (all_outs() !== {1'b1, 21'd0}) begin
            errors++;
            $display("FAIL reset_state outputs=%b expected %b", all_outs(), {1'b1, 21'd0});
        end
        reset = 1'b1;
    endtask

    task automatic test_load_basic();
        run_load(3, 3, 2, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_store_aw_late();
        run_store(2, 5, 100, 1, 2'b00, 1'b0);
    endtask

    task automatic test_priority();
        run_load(2, 2, 0, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        run_store(1, 0, 100, 0, 2'b00, 1'b0);
    endtask

    task automatic test_rlast_errors();
        run_load(1, 0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        run_load(3, 3, 1, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        run_load(2, 4, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_store_single_and_reset();
        run_store(0, 0, 100, 0, 2'b01, 1'b0);
        @(negedge clk);
        st_req    = 1'b1;
        burst_len = 8'd3;
        @(negedge clk);
        st_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (all_outs() !== {1'b1, 21'd0}) begin
            errors++;
            $display("FAIL reset_mid_wr outputs=%b expected %b", all_outs(), {1'b1, 21'd0});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        run_load(1, 1, 0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        run_store(3, 1, 70, 1, 2'b11, 1'b1);
        run_load(0, 0, 1, 1'b0, 1'b1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_load_random();
        int len, rl, kind;
        for (int n = 0; n < 12; n++) begin
            len  = $urandom_range(0, 7);
            kind = $urandom_range(0, 3);
            if (kind == 0 && len > 0)      rl = $urandom_range(0, len - 1);
            else if (kind <= 1)            rl = len + $urandom_range(1, 2);
            else                           rl = len;
            run_load(len, rl, $urandom_range(0, 3), 1'b1, 1'b1, -1, 1'b0, n[0]);
        end
    endtask

    task automatic test_store_random();
        for (int n = 0; n < 12; n++) begin
            run_store($urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(30, 100),
                      $urandom_range(0, 3), 2'($urandom_range(0, 3)), n[0]);
        end
    endtask

`ifdef AXI4_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int hi;
        hi = 0;
        drive_idle();
        @(negedge clk);
        ld_req    = 1'b1;
        burst_len = 8'd3;
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        while (axi.m_arvalid === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (hi != TMO) begin
            errors++;
            $display("FAIL timeout_len arvalid high %0d cycles, expected %0d", hi, TMO);
        end
        checks++;
        if ({axi.m_arvalid, done, err_timeout, resp, req_ready} !== 6'b011101) begin
            errors++;
            $display("FAIL timeout_done {arv,done,err_tmo,resp,rdy}=%b expected 011101",
                     {axi.m_arvalid, done, err_timeout, resp, req_ready});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({done, err_timeout} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse {done,err_tmo}=%b expected 00", {done, err_timeout});
        end
    endtask
`else
    task automatic test_long_stall();
        run_load(1, 1, 40, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_load_basic();
        test_store_aw_late();
        test_priority();
        test_rlast_errors();
        test_store_single_and_reset();
        test_back_to_back();
        test_load_random();
        test_store_random();
`ifdef AXI4_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_long_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
